// File: rtl/byte_striping_pkg.sv
// byte_striping_pkg: PCIe PHY K-codes, striping FSM states and ordered-set detection.
package byte_striping_pkg;
  localparam logic [7:0] K_COM  = 8'hBC;
  localparam logic [7:0] K_SKP  = 8'h1C;
  localparam logic [7:0] K_FTS  = 8'h3C;
  localparam logic [7:0] K_STP  = 8'hFB;
  localparam logic [7:0] K_SDP  = 8'h5C;
  localparam logic [7:0] K_END  = 8'hFD;
  localparam logic [7:0] K_EDB  = 8'hFE;
  localparam logic [7:0] K_PAD  = 8'hF7;
  localparam logic [7:0] K_IDLE = 8'h7C;
  typedef enum logic {S_FILL = 1'b0, S_BCAST_PEND = 1'b1} state_t;
  function automatic logic is_os(input logic k, input logic [7:0] b);
    return k & (b == K_COM || b == K_SKP || b == K_FTS);
  endfunction
endpackage

// File: rtl/byte_striping_lane_map.sv
// strip_lane_map: logical->physical lane permutation; reversed when BYTE_STRIP_LANE_REVERSE_EN is defined.
module strip_lane_map #(
  parameter int LANES = 4
) (
  input  logic [LANES*8-1:0] log_data,
  input  logic [LANES-1:0]   log_k,
  output logic [LANES*8-1:0] lane_data,
  output logic [LANES-1:0]   lane_k
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef BYTE_STRIP_LANE_REVERSE_EN
    assign lane_data[8*i +: 8] = log_data[8*(LANES-1-i) +: 8];
    assign lane_k[i] = log_k[LANES-1-i];
`else
    assign lane_data[8*i +: 8] = log_data[8*i +: 8];
    assign lane_k[i] = log_k[i];
`endif
  end
endmodule

// File: rtl/byte_striping.sv
// byte_striping: stripes a TX byte stream round-robin over LANES lanes, broadcasting COM/SKP/FTS.
// Lane order is reversed when BYTE_STRIP_LANE_REVERSE_EN is defined.
module byte_striping
  import byte_striping_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enb,
  input  logic [7:0]         in_byte,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [LANES*8-1:0] lane_data,
  output logic [LANES-1:0]   lane_k,
  output logic               row_valid,
  output logic               err_drop
);
  localparam int PW = $clog2(LANES);
  state_t state, state_nx;
  logic [PW-1:0] ptr;
  logic [LANES*8-1:0] acc_data, fill_data, pad_data, log_data;
  logic [LANES-1:0] acc_k, fill_k, pad_k, log_k;
  logic [7:0] pend;
  logic accept, k, os, last;
  assign accept = enb & in_ready;
  assign k = !in_valid;
  assign os = is_os(k, in_byte);
  assign last = ptr == PW'(LANES - 1);
  always_ff @(posedge clk)
    state <= rst ? S_FILL : state_nx;
  always_comb
    state_nx = (state == S_FILL && accept && os && ptr != '0) ? S_BCAST_PEND : S_FILL;
  always_comb
    in_ready = state == S_FILL;
  // fill_data is the row as it would look with the current byte merged; pad_data pads lanes >= ptr
  always_comb begin
    fill_data = acc_data;
    fill_k = acc_k;
    fill_data[8*ptr +: 8] = in_byte;
    fill_k[ptr] = k;
    pad_data = acc_data;
    pad_k = acc_k;
    for (int i = 0; i < LANES; i++) begin
      pad_data[8*i +: 8] = (i >= int'(ptr)) ? K_PAD : acc_data[8*i +: 8];
      pad_k[i] = (i >= int'(ptr)) | acc_k[i];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      acc_data <= '0;
      acc_k <= '0;
      pend <= '0;
      log_data <= '0;
      log_k <= '0;
      row_valid <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      row_valid <= 1'b0;
      if (enb && !in_ready) err_drop <= 1'b1;
      if (state == S_BCAST_PEND) begin
        log_data <= {LANES{pend}};
        log_k <= '1;
        row_valid <= 1'b1;
        pend <= '0;
      end else if (accept && os) begin
        ptr <= '0;
        pend <= in_byte;
        log_data <= (ptr == '0) ? {LANES{in_byte}} : pad_data;
        log_k <= (ptr == '0) ? '1 : pad_k;
        row_valid <= 1'b1;
      end else if (accept) begin
        acc_data <= fill_data;
        acc_k <= fill_k;
        ptr <= last ? '0 : ptr + PW'(1);
        if (last) begin
          log_data <= fill_data;
          log_k <= fill_k;
          row_valid <= 1'b1;
        end
      end
    end
  end
  strip_lane_map #(.LANES(LANES)) u_map (
    .log_data (log_data),
    .log_k    (log_k),
    .lane_data(lane_data),
    .lane_k   (lane_k)
  );
endmodule

// File: tb/tb_byte_striping.sv
// tb_byte_striping: directed checks of striping, ordered-set broadcast, padding, drop and reset.
module tb_byte_striping;
  logic clk = 0, rst = 1, enb = 0, in_valid = 1;
  logic [7:0] in_byte = 0;
  logic in_ready, row_valid, err_drop;
  logic [31:0] lane_data;
  logic [3:0] lane_k;
  int n_chk = 0, n_fail = 0;

  byte_striping #(.LANES(4)) dut (
    .clk(clk), .rst(rst), .enb(enb), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .lane_data(lane_data), .lane_k(lane_k),
    .row_valid(row_valid), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] md(input logic [31:0] d);
`ifdef BYTE_STRIP_LANE_REVERSE_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  function automatic logic [3:0] mk(input logic [3:0] k);
`ifdef BYTE_STRIP_LANE_REVERSE_EN
    return {k[0], k[1], k[2], k[3]};
`else
    return k;
`endif
  endfunction

  task automatic step(input logic e, input logic [7:0] b, input logic v);
    enb = e;
    in_byte = b;
    in_valid = v;
    @(posedge clk);
    #1;
    enb = 0;
  endtask

  task automatic row(input string tag, input logic [31:0] d, input logic [3:0] k);
    check({tag, " rv"}, 32'(row_valid), 32'd1);
    check({tag, " data"}, lane_data, md(d));
    check({tag, " k"}, 32'(lane_k), 32'(mk(k)));
  endtask

  initial begin
    step(0, 8'h00, 1);
    check("rst data", lane_data, 32'h0);
    check("rst k", 32'(lane_k), 32'h0);
    check("rst rv", 32'(row_valid), 32'h0);
    check("rst ready", 32'(in_ready), 32'h1);
    check("rst err", 32'(err_drop), 32'h0);
    step(1, 8'h99, 1);
    check("rst ignores enb", 32'(row_valid), 32'h0);
    rst = 0;
    // 1: plain data row
    step(1, 8'h11, 1); step(1, 8'h22, 1); step(1, 8'h33, 1);
    check("t1 no early row", 32'(row_valid), 32'h0);
    step(1, 8'h44, 1);
    row("t1", 32'h44332211, 4'b0000);
    step(0, 8'h00, 1);
    check("t1 rv pulse", 32'(row_valid), 32'h0);
    check("t1 hold", lane_data, md(32'h44332211));
    // 2: back-to-back ordered sets at lane 0
    step(1, 8'hBC, 0);
    row("t2 com", 32'hBCBCBCBC, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      step(1, 8'h1C, 0);
      row("t2 skp", 32'h1C1C1C1C, 4'b1111);
      check("t2 ready", 32'(in_ready), 32'h1);
    end
    step(0, 8'h00, 1);
    check("t2 end", 32'(row_valid), 32'h0);
    // 3+4: padded row, pending broadcast, byte dropped while not ready
    step(1, 8'h11, 1); step(1, 8'h22, 1);
    step(1, 8'h1C, 0);
    row("t3 pad", 32'hF7F72211, 4'b1100);
    check("t3 not ready", 32'(in_ready), 32'h0);
    step(1, 8'h55, 1);
    row("t3 bcast", 32'h1C1C1C1C, 4'b1111);
    check("t3 ready back", 32'(in_ready), 32'h1);
    check("t4 err", 32'(err_drop), 32'h1);
    step(1, 8'h66, 1); step(1, 8'h77, 1); step(1, 8'h88, 1);
    check("t4 no row", 32'(row_valid), 32'h0);
    step(1, 8'h99, 1);
    row("t4 no 55", 32'h99887766, 4'b0000);
    check("t4 err sticky", 32'(err_drop), 32'h1);
    // non-ordered-set control char stripes like data; FTS broadcasts
    step(1, 8'hFB, 0); step(1, 8'h01, 1); step(1, 8'h02, 1); step(1, 8'h03, 1);
    row("stp", 32'h030201FB, 4'b0001);
    step(1, 8'h3C, 0);
    row("fts", 32'h3C3C3C3C, 4'b1111);
    // padding from lane 3
    step(1, 8'hA1, 1); step(1, 8'hA2, 1); step(1, 8'hA3, 1);
    step(1, 8'hBC, 0);
    row("pad1", 32'hF7A3A2A1, 4'b1000);
    step(0, 8'h00, 1);
    row("pad1 bcast", 32'hBCBCBCBC, 4'b1111);
    // 5: reset mid-row discards partial row and clears err_drop
    step(1, 8'h11, 1); step(1, 8'h22, 1); step(1, 8'h33, 1);
    rst = 1;
    step(1, 8'hEE, 1);
    rst = 0;
    check("t5 err clr", 32'(err_drop), 32'h0);
    check("t5 rv", 32'(row_valid), 32'h0);
    step(1, 8'hAA, 1); step(1, 8'hBB, 1); step(1, 8'hCC, 1);
    check("t5 no stale row", 32'(row_valid), 32'h0);
    step(1, 8'hDD, 1);
    row("t5", 32'hDDCCBBAA, 4'b0000);
    step(0, 8'h00, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
